// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: HI/LO registers, multi-cycle busy window.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mduOp,
    input  logic        start,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    logic [CW-1:0] cnt;
    logic [31:0]   p_hi, p_lo;
    logic [63:0]   prod_s, prod_u, result;
    logic [31:0]   mag_a, mag_b, q_mag, r_mag, quot, rem;
    logic          sgn_div, div_zero, is_mul, is_div;

    always_comb begin
        prod_s   = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prod_u   = {32'd0, srcA} * {32'd0, srcB};
        // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 naturally.
        sgn_div  = (mduOp == OP_DIV);
        div_zero = (srcB == 32'd0);
        mag_a    = (sgn_div && srcA[31]) ? -srcA : srcA;
        mag_b    = (sgn_div && srcB[31]) ? -srcB : srcB;
        q_mag    = div_zero ? 32'd0 : mag_a / mag_b;
        r_mag    = div_zero ? 32'd0 : mag_a % mag_b;
        quot     = (sgn_div && (srcA[31] ^ srcB[31])) ? -q_mag : q_mag;
        rem      = (sgn_div && srcA[31]) ? -r_mag : r_mag;

        is_mul = 1'b0;
        is_div = 1'b0;
        result = {hi, lo};
        case (mduOp)
            OP_MULT:  begin is_mul = 1'b1; result = prod_s; end
            OP_MULTU: begin is_mul = 1'b1; result = prod_u; end
            OP_DIV, OP_DIVU: begin
                is_div = 1'b1;
                // Divide by zero completes with HI/LO untouched.
                if (!div_zero) result = {rem, quot};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; result = {hi, lo} + prod_s; end
            OP_MADDU: begin is_mul = 1'b1; result = {hi, lo} + prod_u; end
            OP_MSUB:  begin is_mul = 1'b1; result = {hi, lo} - prod_s; end
            OP_MSUBU: begin is_mul = 1'b1; result = {hi, lo} - prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
        end else if (busy) begin
            cnt  <= cnt - CW'(1);
            busy <= (cnt != CW'(1));
            if (cnt == CW'(1)) {hi, lo} <= {p_hi, p_lo};
        end else if (start) begin
            if (is_mul) begin
                cnt          <= CW'(MULT_CYCLES);
                busy         <= 1'b1;
                {p_hi, p_lo} <= result;
            end else if (is_div) begin
                cnt          <= CW'(DIV_CYCLES);
                busy         <= 1'b1;
                {p_hi, p_lo} <= result;
            end else if (mduOp == OP_MTHI) begin
                hi <= srcA;
            end else if (mduOp == OP_MTLO) begin
                lo <= srcA;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver predicts HI/LO and busy length, monitor checks on completion.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mduOp = 4'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .mduOp(mduOp), .start(start),
        .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Reference model: architectural HI/LO semantics in plain integer arithmetic.
    task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        int                sa, sb2;
        longint            ps;
        longint unsigned   pu;
        logic [63:0]       acc;
        sa = a; sb2 = b;
        ps = longint'(sa) * longint'(sb2);
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        acc = {m_hi, m_lo};
        n = 0;
        case (op)
            4'd1: begin n = MC; {m_hi, m_lo} = ps; end
            4'd2: begin n = MC; {m_hi, m_lo} = pu; end
            4'd3: begin
                n = DC;
                if (b == 0) ;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = sa / sb2; m_hi = sa % sb2; end
            end
            4'd4: begin n = DC; if (b != 0) begin m_lo = a / b; m_hi = a % b; end end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin n = MC; {m_hi, m_lo} = acc + ps; end
            4'd8:  begin n = MC; {m_hi, m_lo} = acc + pu; end
            4'd9:  begin n = MC; {m_hi, m_lo} = acc - ps; end
            4'd10: begin n = MC; {m_hi, m_lo} = acc - pu; end
`endif
            default: ;
        endcase
    endtask

    // Entered at posedge+2 with busy low; returns the same way after completion.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t;
        predict(op, a, b, e.n);
        e.h = m_hi; e.l = m_lo;
        sb.push_back(e);
        mduOp = op; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        t = 0;
        while (busy && t < 50) begin @(posedge clk); #2; t++; end
        if (busy) begin
            n_fail++;
            $display("FAIL drv_timeout: busy still 1 after %0d cycles, want 0", t);
        end
    endtask

    // Monitor: sees an accept on the interface, then times busy and checks HI/LO at completion.
    initial begin
        bit          fresh;
        exp_t        e;
        int          k;
        logic [31:0] h0, l0;
        fresh = 1'b0;
        forever begin
            if (!fresh) @(negedge clk);
            fresh = 1'b0;
            if (rst_n && start && !busy) begin
                h0 = hi; l0 = lo; k = 0;
                e.n = -1; e.h = 'x; e.l = 'x;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got accept, want queued expectation");
                end else e = sb.pop_front();
                @(negedge clk);
                while (busy && k < 60) begin
                    k++;
                    check("hold_hilo", {hi, lo}, {h0, l0});
                    @(negedge clk);
                end
                check("busy_len", k, e.n);
                check("hi", hi, e.h);
                check("lo", lo, e.l);
                fresh = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          r;

        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("tp_mult_hi", hi, 32'hFFFF_FFFF);
        check("tp_mult_lo", lo, 32'hFFFF_FFFA);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        check("tp_multu_hi", hi, 32'h0000_0002);
        check("tp_multu_lo", lo, 32'hFFFF_FFFA);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("tp_div_hi", hi, 32'hFFFF_FFFF);
        check("tp_div_lo", lo, 32'hFFFF_FFFD);
        issue(4'd5, 32'h1234, 32'd0);
        issue(4'd6, 32'h5678, 32'd0);
        issue(4'd4, 32'd7, 32'd0);
        check("tp_div0_hi", hi, 32'h1234);
        check("tp_div0_lo", lo, 32'h5678);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("tp_divovf_hi", hi, 32'd0);
        check("tp_divovf_lo", lo, 32'h8000_0000);

        // Reset pulled in the third busy cycle of a MULT.
        issue(4'd5, 32'hDEAD, 32'd0);
        e.n = 2; e.h = 0; e.l = 0;
        sb.push_back(e);
        m_hi = 0; m_lo = 0;
        mduOp = 4'd1; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        issue(4'd6, 32'hAB, 32'd0);
        check("tp_mtlo_after_rst", lo, 32'hAB);

        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd5, 32'd0);
        issue(4'd7, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
        check("tp_madd_lo", lo, 32'd11);
`else
        check("tp_madd_lo", lo, 32'd5);
`endif
        check("tp_madd_hi", hi, 32'd0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            a  = (r < 3) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = (r < 5) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            if (r == 9) b = 32'd0;
            if (r == 8) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(op, a, b);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
